score_display_ctrl: RTL

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Converts a 16-bit binary score to BCD with a 16-cycle shift-add-3
//   (double-dabble) converter and arbitrates the seven-segment digit bus
//   between the score and a timed message. A message that is on display
//   takes priority. When it expires, the current score is shown again.
//
//   Optional feature: define SCORE_DISPLAY_BLINK_EN to make message digits
//   blink (blank mask alternates 8'h00 / 8'hFF every BLINK_HALF cycles).
//
// Ports
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-high reset
//   score_in        : binary score, accepted when score_valid_in & score_ready_out
//   score_valid_in  : score_in valid
//   score_ready_out : converter idle, can accept a score
//   msg_req_in      : one-cycle request to show msg_val_in
//   msg_val_in      : eight 4-bit digit codes, [3:0] rightmost
//   val_out         : registered digit codes, [3:0] ones digit
//   blank_out       : registered per-digit blank mask
//   msg_active_out  : message currently displayed
//   busy_out        : conversion in progress
module score_display_ctrl #(
  parameter int unsigned MSG_HOLD_CYCLES = 100_000_000,
  parameter int unsigned BLINK_HALF      = 25_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] score_in,
  input  logic        score_valid_in,
  output logic        score_ready_out,
  input  logic        msg_req_in,
  input  logic [31:0] msg_val_in,
  output logic [31:0] val_out,
  output logic [7:0]  blank_out,
  output logic        msg_active_out,
  output logic        busy_out
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  localparam logic [31:0] HOLD_LOAD = 32'(MSG_HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic        accept;
  logic        conv_last;

  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  iter_q;
  logic [19:0] bcd_adj;
  logic [19:0] bcd_sh;

  logic [31:0] score_q, score_nxt;
  logic [7:0]  score_blank;

  logic [31:0] msg_q, msg_nxt;
  logic        msg_active_q, msg_active_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [7:0]  msg_blank;

  // ---------------- converter FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (score_valid_in) state_nxt = CONV;
      CONV: if (iter_q == 4'd15) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    score_ready_out = 1'b0;
    busy_out        = 1'b0;
    case (state)
      IDLE:    score_ready_out = 1'b1;
      CONV:    busy_out        = 1'b1;
      default: score_ready_out = 1'b1;
    endcase
  end

  assign accept    = (state == IDLE) && score_valid_in;
  assign conv_last = (state == CONV) && (iter_q == 4'd15);

  // ---------------- double-dabble datapath ----------------
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned d = 0; d < 5; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[18:0], bin_q[15]};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (accept) begin
      bin_q  <= score_in;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (state == CONV) begin
      bin_q  <= {bin_q[14:0], 1'b0};
      bcd_q  <= bcd_sh;
      iter_q <= iter_q + 4'd1;
    end
  end

  // The score register takes the result of the 16th shift on the same edge.
  always_comb begin
    score_nxt = score_q;
    if (conv_last) score_nxt = {12'h000, bcd_sh};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) score_q <= '0;
    else        score_q <= score_nxt;
  end

  // Leading-zero blanking: digit i blanks if it and all digits above are zero.
  always_comb begin
    logic zero_above;
    score_blank = '0;
    zero_above  = 1'b1;
    for (int unsigned i = 7; i >= 1; i--) begin
      if (score_nxt[4*i +: 4] != 4'd0) zero_above = 1'b0;
      score_blank[i] = zero_above;
    end
  end

  // ---------------- message hold ----------------
  always_comb begin
    msg_nxt        = msg_q;
    msg_active_nxt = msg_active_q;
    hold_nxt       = hold_q;
    if (msg_req_in) begin
      msg_nxt        = msg_val_in;
      msg_active_nxt = 1'b1;
      hold_nxt       = HOLD_LOAD;
    end else if (msg_active_q) begin
      if (hold_q == '0) msg_active_nxt = 1'b0;
      else              hold_nxt       = hold_q - 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      msg_q        <= '0;
      msg_active_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      msg_q        <= msg_nxt;
      msg_active_q <= msg_active_nxt;
      hold_q       <= hold_nxt;
    end
  end

  assign msg_active_out = msg_active_q;

`ifdef SCORE_DISPLAY_BLINK_EN
  localparam logic [31:0] BLINK_LOAD = 32'(BLINK_HALF - 1);

  logic [31:0] blink_cnt_q, blink_cnt_nxt;
  logic        blink_ph_q, blink_ph_nxt;

  // Phase 0 (digits visible) first; every request restarts the pattern.
  always_comb begin
    blink_cnt_nxt = blink_cnt_q;
    blink_ph_nxt  = blink_ph_q;
    if (msg_req_in) begin
      blink_cnt_nxt = BLINK_LOAD;
      blink_ph_nxt  = 1'b0;
    end else if (msg_active_q) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_nxt = BLINK_LOAD;
        blink_ph_nxt  = ~blink_ph_q;
      end else begin
        blink_cnt_nxt = blink_cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_nxt;
      blink_ph_q  <= blink_ph_nxt;
    end
  end

  assign msg_blank = blink_ph_nxt ? 8'hFF : 8'h00;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_HALF;
  assign msg_blank        = 8'h00;
`endif

  // ---------------- registered display outputs ----------------
  // Driven from next-state values so the display tracks the same edge on
  // which the score register or message state changes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_out   <= '0;
      blank_out <= 8'hFE;
    end else if (msg_active_nxt) begin
      val_out   <= msg_nxt;
      blank_out <= msg_blank;
    end else begin
      val_out   <= score_nxt;
      blank_out <= score_blank;
    end
  end

endmodule
